// File: rtl/rv32_cu_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : rv32_cu_pkg                                                   |
// | Brief    : State encoding and widths for the RV32 multicycle control FSM |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv32_cu_pkg;

  localparam int c_STATE_W = 3;
  localparam int c_WE_W    = 4;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_EXECUTE    = 3'd4,
    ST_MEM        = 3'd5,
    ST_WRITEBACK  = 3'd6,
    ST_HALT       = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rv32_fsm_control_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : rv32_fsm_control_unit                                         |
// | Brief    : Six-state-per-instruction control FSM driving PC/IMem/RF/DMem |
// |            enables from decoder flags. Define CU_DEBUG_STATE_EN to       |
// |            expose the current state on dbg_state.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv32_fsm_control_unit
  import rv32_cu_pkg::*;
#(
  parameter int WE_W = c_WE_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            store,
  input  logic            branch,
  input  logic            fence,
  input  logic [WE_W-1:0] decoder_dmem_we,
  input  logic            halt,
  output logic            pc_we,
  output logic            imem_rd,
  output logic            rf_we,
  output logic [WE_W-1:0] dmem_we,
  output logic            dmem_rd
`ifdef CU_DEBUG_STATE_EN
  ,
  output logic [c_STATE_W-1:0] dbg_state
`endif
);

  state_t r_state;

  logic w_is_fence;
  logic w_is_store;
  logic w_is_load;
  logic w_is_alu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       r_state <= ST_FETCH;
        ST_FETCH:      r_state <= ST_FETCH_WAIT;
        ST_FETCH_WAIT: r_state <= ST_DECODE;
        ST_DECODE:     r_state <= halt ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE:    r_state <= ST_MEM;
        ST_MEM:        r_state <= ST_WRITEBACK;
        ST_WRITEBACK:  r_state <= ST_FETCH;
        ST_HALT:       r_state <= ST_HALT;
        default:       r_state <= ST_IDLE;
      endcase
    end
  end

  // Class priority: halt > fence > store > load > branch > ALU
  assign w_is_fence = !halt && fence;
  assign w_is_store = !halt && !fence && store;
  assign w_is_load  = !halt && !fence && !store && load;
  assign w_is_alu   = !halt && !fence && !store && !load && !branch;

  always_comb begin
    pc_we   = 1'b0;
    imem_rd = 1'b0;
    rf_we   = 1'b0;
    dmem_we = '0;
    dmem_rd = 1'b0;
    case (r_state)
      ST_FETCH, ST_FETCH_WAIT: imem_rd = 1'b1;
      ST_MEM:                  dmem_rd = w_is_load;
      ST_WRITEBACK: begin
        pc_we   = !halt;
        rf_we   = w_is_load || w_is_alu;
        dmem_we = w_is_store ? decoder_dmem_we : '0;
        dmem_rd = w_is_load;
      end
      default: ;
    endcase
  end

`ifdef CU_DEBUG_STATE_EN
  assign dbg_state = r_state;
`endif

  // Fence only matters through the priority chain above.
  logic w_unused;
  assign w_unused = w_is_fence;

endmodule

`default_nettype wire

// File: tb/tb_rv32_fsm_control_unit.sv
// Self-checking bench for rv32_fsm_control_unit: directed literal cases plus
// randomized instruction streams compared against a phase-count model.
`default_nettype none

module tb_rv32_fsm_control_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load, store, branch, fence, halt;
  logic [3:0] decoder_dmem_we;
  logic       pc_we, imem_rd, rf_we, dmem_rd;
  logic [3:0] dmem_we;
`ifdef CU_DEBUG_STATE_EN
  logic [2:0] dbg_state;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv32_fsm_control_unit #(.WE_W(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .load            (load),
    .store           (store),
    .branch          (branch),
    .fence           (fence),
    .decoder_dmem_we (decoder_dmem_we),
    .halt            (halt),
    .pc_we           (pc_we),
    .imem_rd         (imem_rd),
    .rf_we           (rf_we),
    .dmem_we         (dmem_we),
    .dmem_rd         (dmem_rd)
`ifdef CU_DEBUG_STATE_EN
    ,
    .dbg_state       (dbg_state)
`endif
  );

  // Model: step counts clock edges into the instruction (0 = idle after reset,
  // 1..6 = fetch..writeback), halted latches once a halting instruction decodes.
  int m_step   = 0;
  bit m_halted = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_step   <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_step == 3 && halt) m_halted <= 1'b1;
      else                     m_step   <= (m_step == 6) ? 1 : m_step + 1;
    end
  end

  function automatic logic [7:0] dut_outs();
    return {pc_we, imem_rd, rf_we, dmem_rd, dmem_we};
  endfunction

  function automatic logic [7:0] model_outs();
    bit is_store, is_load, is_alu, run;
    logic [7:0] o;
    run      = !m_halted;
    is_store = !halt && !fence && store;
    is_load  = !halt && !fence && !store && load;
    is_alu   = !halt && !fence && !store && !load && !branch;
    o = 8'h00;
    o[7]   = run && m_step == 6 && !halt;
    o[6]   = run && (m_step == 1 || m_step == 2);
    o[5]   = run && m_step == 6 && (is_load || is_alu);
    o[4]   = run && (m_step == 5 || m_step == 6) && is_load;
    o[3:0] = (run && m_step == 6 && is_store) ? decoder_dmem_we : 4'h0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_cycle", dut_outs(), model_outs());
  end

  task automatic start(input logic l, s, b, f, h, input logic [3:0] we);
    @(posedge clk); #1;
    rstn = 1'b0;
    load = l; store = s; branch = b; fence = f; halt = h;
    decoder_dmem_we = we;
    #1 chk("reset_outs", dut_outs(), 8'h00);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    {load, store, branch, fence, halt} = 5'b0;
    decoder_dmem_we = 4'h0;
    repeat (2) @(posedge clk);

    // ALU
    start(0, 0, 0, 0, 0, 4'h0);
    edges(1); chk("alu_fetch",  dut_outs(), 8'b0100_0000);
    edges(2); chk("alu_decode", dut_outs(), 8'b0000_0000);
    edges(3); chk("alu_wb",     dut_outs(), 8'b1010_0000);
    edges(1); chk("alu_next_fetch", dut_outs(), 8'b0100_0000);

    // Store
    start(0, 1, 0, 0, 0, 4'b1111);
    edges(5); chk("store_mem", dut_outs(), 8'b0000_0000);
    edges(1); chk("store_wb",  dut_outs(), 8'b1000_1111);

    // Load
    start(1, 0, 0, 0, 0, 4'h0);
    edges(5); chk("load_mem", dut_outs(), 8'b0001_0000);
    edges(1); chk("load_wb",  dut_outs(), 8'b1011_0000);

    // Branch
    start(0, 0, 1, 0, 0, 4'h0);
    edges(6); chk("branch_wb", dut_outs(), 8'b1000_0000);

    // Halt is absorbing
    start(1, 1, 0, 0, 1, 4'b1111);
    edges(4);
    for (int i = 0; i < 12; i++) begin
      chk("halt_hold", dut_outs(), 8'b0000_0000);
      edges(1);
    end

    // Fence
    start(1, 0, 1, 1, 0, 4'b1111);
    edges(6); chk("fence_wb",    dut_outs(), 8'b1000_0000);
    edges(1); chk("fence_fetch", dut_outs(), 8'b0100_0000);

    // Async reset in MEM
    start(1, 0, 0, 0, 0, 4'h0);
    edges(5); chk("async_pre", dut_outs(), 8'b0001_0000);
    #2 rstn = 1'b0;
    #1 chk("async_reset", dut_outs(), 8'b0000_0000);
    @(posedge clk); #1 rstn = 1'b1;
    edges(1); chk("async_restart_fetch", dut_outs(), 8'b0100_0000);
    edges(5); chk("async_restart_wb",    dut_outs(), 8'b1011_0000);

    // Randomized instruction streams
    begin
      int halted_cycles = 0;
      for (int c = 0; c < 4000; c++) begin
        @(posedge clk); #1;
        if (m_halted) begin
          halted_cycles++;
          if (halted_cycles > 5) begin
            rstn = 1'b0;
            #2 rstn = 1'b1;
            halted_cycles = 0;
          end
        end else if ($urandom_range(0, 199) == 0) begin
          rstn = 1'b0;
          #2 rstn = 1'b1;
        end else if (m_step <= 1) begin
          load            = 1'($urandom_range(0, 1));
          store           = 1'($urandom_range(0, 1));
          branch          = 1'($urandom_range(0, 1));
          fence           = ($urandom_range(0, 3) == 0);
          halt            = ($urandom_range(0, 9) == 0);
          decoder_dmem_we = 4'($urandom_range(0, 15));
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
